uart_frame_monitor: RTL and testbench

UART_FRAME_MONITOR -- requirements
Module: uart_frame_monitor

---
 rtl/uart_mon_pkg.sv | 28 ++
 rtl/uart_mon_fifo.sv | 67 ++++++
 rtl/uart_frame_monitor.sv | 143 ++++++++++++++
 tb/tb_uart_frame_monitor.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mon_pkg.sv
// Shared types for the UART frame monitor: deframer states, parity-mode
// encodings and the capture FIFO entry layout.
package uart_mon_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_WAIT_IDLE
   } mon_state_t;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   // Widest legal frame payload; narrower frames are zero-extended.
   localparam int MAX_DATA_BITS = 9;

   typedef struct packed {
      logic [MAX_DATA_BITS-1:0] data;
      logic                     perr;
      logic                     ferr;
      logic                     brk;
   } mon_entry_t;

endpackage

// File: rtl/uart_mon_fifo.sv
// First-word-fall-through capture FIFO with sticky overflow and a
// saturating dropped-frame counter.
module uart_mon_fifo
   import uart_mon_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  mon_entry_t push_entry,
   input  logic       ready,
   output logic       valid,
   output mon_entry_t head,
   output logic       overflow,
   output logic [15:0] drop_cnt
);
   localparam int AW = $clog2(DEPTH);

   mon_entry_t      mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     count;
   logic            full;
   logic            pop;
   logic            accept;
   logic            drop;

   assign full   = (count == (AW+1)'(DEPTH));
   assign valid  = (count != '0);
   assign pop    = valid && ready;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign accept = push && (!full || pop);
   assign drop   = push && full && !pop;
   assign head   = valid ? mem[rd_ptr] : '0;

   // NOTE: the storage array is deliberately not reset; count and pointers
   // alone decide which words are live, and head is masked while empty.
   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr] <= push_entry;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // sees the pre-edge value of every other register.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + 1'b1;
         if (pop)    rd_ptr <= rd_ptr + 1'b1;
         case ({accept, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_frame_monitor.sv
// Passive UART line monitor: synchronises the line, deframes characters and
// captures {data, perr, ferr, break} per frame into a FWFT FIFO.
module uart_frame_monitor
   import uart_mon_pkg::*;
#(
   parameter int DATA_BITS    = 8,
   parameter int PARITY_MODE  = 0,
   parameter int STOP_BITS    = 1,
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 line_i,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [DATA_BITS-1:0] m_data,
   output logic                 m_perr,
   output logic                 m_ferr,
   output logic                 m_break,
   output logic                 overflow,
   output logic [15:0]          drop_cnt,
   output logic                 busy
);
   localparam int CW   = $clog2(CLKS_PER_BIT);
   localparam int HALF = CLKS_PER_BIT / 2;

   mon_state_t           state, state_next;
   logic                 sync_q1, sync_q2, line_d, line_s;
   logic [CW-1:0]        cnt;
   logic [3:0]           bit_idx;
   logic                 stop_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_q, ferr_q, first_low_q;
   logic                 bit_tick, last_stop, push;
   logic                 first_low, perr_now, brk_now;
   mon_entry_t           push_entry, head;
   logic                 unused_head_bits;

   assign line_s    = sync_q2;
   assign busy      = (state != ST_IDLE);
   // Start bit is checked mid-bit; every later bit one full period after.
   assign bit_tick  = (state == ST_START) ? (cnt == CW'(HALF))
                                          : (cnt == CW'(CLKS_PER_BIT - 1));
   assign last_stop = (STOP_BITS == 1) || stop_idx;
   assign first_low = stop_idx ? first_low_q : ~line_s;
   assign perr_now  = (PARITY_MODE == PARITY_EVEN) ?  (^{shreg, par_q}) :
                      (PARITY_MODE == PARITY_ODD)  ? ~(^{shreg, par_q}) : 1'b0;
   assign brk_now   = (shreg == '0) && ((PARITY_MODE == PARITY_NONE) || !par_q)
                      && first_low;

   assign push_entry.data = MAX_DATA_BITS'(shreg);
   assign push_entry.perr = perr_now;
   assign push_entry.ferr = ferr_q | ~line_s;
   assign push_entry.brk  = brk_now;

   // NOTE: every output of this block gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      state_next = state;
      push       = 1'b0;
      if (!enable) begin
         state_next = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:      if (line_d && !line_s) state_next = ST_START;
            ST_START:     if (bit_tick) state_next = line_s ? ST_IDLE : ST_DATA;
            ST_DATA:      if (bit_tick && bit_idx == 4'(DATA_BITS - 1))
                             state_next = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
            ST_PARITY:    if (bit_tick) state_next = ST_STOP;
            ST_STOP:      if (bit_tick && last_stop) begin
                             push       = 1'b1;
                             state_next = line_s ? ST_IDLE : ST_WAIT_IDLE;
                          end
            ST_WAIT_IDLE: if (line_s) state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         sync_q1     <= 1'b1;
         sync_q2     <= 1'b1;
         line_d      <= 1'b1;
         cnt         <= '0;
         bit_idx     <= '0;
         stop_idx    <= 1'b0;
         shreg       <= '0;
         par_q       <= 1'b0;
         ferr_q      <= 1'b0;
         first_low_q <= 1'b0;
      end else begin
         state   <= state_next;
         sync_q1 <= line_i;
         sync_q2 <= sync_q1;
         line_d  <= sync_q2;
         cnt     <= (state == ST_IDLE || bit_tick) ? '0 : cnt + 1'b1;
         if (bit_tick) begin
            case (state)
               ST_START: begin
                  bit_idx  <= '0;
                  stop_idx <= 1'b0;
                  par_q    <= 1'b0;
                  ferr_q   <= 1'b0;
               end
               ST_DATA: begin
                  shreg   <= {line_s, shreg[DATA_BITS-1:1]};
                  bit_idx <= bit_idx + 1'b1;
               end
               ST_PARITY: par_q <= line_s;
               ST_STOP: begin
                  if (!line_s) ferr_q <= 1'b1;
                  if (!stop_idx) first_low_q <= ~line_s;
                  stop_idx <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   uart_mon_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_entry (push_entry),
      .ready      (m_ready),
      .valid      (m_valid),
      .head       (head),
      .overflow   (overflow),
      .drop_cnt   (drop_cnt)
   );

   assign m_data           = head.data[DATA_BITS-1:0];
   assign m_perr           = head.perr;
   assign m_ferr           = head.ferr;
   assign m_break          = head.brk;
   assign unused_head_bits = ^head.data;

endmodule

// File: tb/tb_uart_frame_monitor.sv
// Self-checking bench: an 8N1 depth-4 monitor against a frame-level model,
// and an 8E1 monitor driven from a table of hand-computed vectors.
module tb_uart_frame_monitor;
   localparam int CPB = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, enable_a, line_a, m_ready_a, enable_b, line_b, m_ready_b;
   logic m_valid_a, m_perr_a, m_ferr_a, m_break_a, overflow_a, busy_a;
   logic m_valid_b, m_perr_b, m_ferr_b, m_break_b, overflow_b, busy_b;
   logic [7:0]  m_data_a, m_data_b;
   logic [15:0] drop_cnt_a, drop_cnt_b;

   uart_frame_monitor #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1),
                        .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) u_dut_a (
      .clk(clk), .rst(rst), .enable(enable_a), .line_i(line_a),
      .m_valid(m_valid_a), .m_ready(m_ready_a), .m_data(m_data_a),
      .m_perr(m_perr_a), .m_ferr(m_ferr_a), .m_break(m_break_a),
      .overflow(overflow_a), .drop_cnt(drop_cnt_a), .busy(busy_a));

   uart_frame_monitor #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1),
                        .CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) u_dut_b (
      .clk(clk), .rst(rst), .enable(enable_b), .line_i(line_b),
      .m_valid(m_valid_b), .m_ready(m_ready_b), .m_data(m_data_b),
      .m_perr(m_perr_b), .m_ferr(m_ferr_b), .m_break(m_break_b),
      .overflow(overflow_b), .drop_cnt(drop_cnt_b), .busy(busy_b));

   typedef struct {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
      logic       brk;
   } exp_t;

   typedef struct {
      logic [7:0] data;
      logic       par;
      logic       stop_low;
      logic       perr;
      logic       ferr;
      logic       brk;
   } vec_t;

   int   n_vec   = 0;
   int   n_fail  = 0;
   int   pops_a  = 0;
   int   drops_a = 0;
   exp_t exp_q[$];
   vec_t tbl[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Frame-level model for an 8N1 line into a 4-deep capture buffer.
   task automatic model_push_a(input logic [7:0] d, input bit stop_low);
      exp_t e;
      e.data = d;
      e.perr = 1'b0;
      e.brk  = (d == 8'h00) && stop_low;
      e.ferr = stop_low;
      if (exp_q.size() < 4) exp_q.push_back(e);
      else drops_a++;
   endtask

   task automatic send_a(input logic [7:0] d, input bit stop_low, input bit rand_rdy);
      logic [9:0] bits;
      bits = {~stop_low, d, 1'b0};
      for (int i = 0; i < 10; i++) begin
         line_a = bits[i];
         for (int c = 0; c < CPB; c++) begin
            tick();
            if (rand_rdy) m_ready_a = 1'($urandom_range(0, 1));
         end
      end
   endtask

   task automatic send_b(input logic [7:0] d, input logic par, input bit stop_low);
      logic [10:0] bits;
      bits = {~stop_low, par, d, 1'b0};
      for (int i = 0; i < 11; i++) begin
         line_b = bits[i];
         tick(CPB);
      end
   endtask

   // Scoreboard for monitor A: head must match the model, and hold while stalled.
   logic       prev_hold = 1'b0;
   logic [7:0] prev_data = 8'h00;
   always @(negedge clk) begin
      if (rst) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            check("a_hold_valid", m_valid_a, 1);
            check("a_hold_data", m_data_a, prev_data);
         end
         if (m_valid_a) begin
            if (exp_q.size() == 0) begin
               check("a_spurious_entry", m_valid_a, 0);
            end else begin
               check("a_data", m_data_a, exp_q[0].data);
               check("a_perr", m_perr_a, exp_q[0].perr);
               check("a_ferr", m_ferr_a, exp_q[0].ferr);
               check("a_break", m_break_a, exp_q[0].brk);
               if (m_ready_a) begin
                  exp_q.delete(0);
                  pops_a++;
               end
            end
         end
         prev_hold = m_valid_a && !m_ready_a;
         prev_data = m_data_a;
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int p0;
      int w;
      logic [7:0] d;
      bit sl;

      // data, parity bit, stop low -> expected perr, ferr, break (even parity)
      tbl[0] = '{8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[4] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[5] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[6] = '{8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[7] = '{8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

      rst = 1'b1; enable_a = 1'b1; enable_b = 1'b1;
      line_a = 1'b1; line_b = 1'b1; m_ready_a = 1'b1; m_ready_b = 1'b0;
      tick(3);
      check("rst_valid_a", m_valid_a, 0);
      check("rst_data_a", m_data_a, 0);
      check("rst_flags_a", {m_perr_a, m_ferr_a, m_break_a}, 0);
      check("rst_overflow_a", overflow_a, 0);
      check("rst_drop_cnt_a", drop_cnt_a, 0);
      check("rst_busy_a", busy_a, 0);
      check("rst_valid_b", m_valid_b, 0);
      check("rst_busy_b", busy_b, 0);
      rst = 1'b0;
      tick(CPB);

      // Clean 8N1 frame.
      p0 = pops_a;
      model_push_a(8'hA5, 0);
      send_a(8'hA5, 0, 0);
      line_a = 1'b1;
      tick(CPB);
      check("a5_entries", pops_a - p0, 1);

      // Short glitch: too short to survive the mid-start check.
      p0 = pops_a;
      line_a = 1'b0;
      tick(5);
      check("glitch_busy_start", busy_a, 1);
      line_a = 1'b1;
      tick(3 * CPB);
      check("glitch_busy_idle", busy_a, 0);
      check("glitch_entries", pops_a - p0, 0);

      // Low stop bit with the line held low afterwards.
      model_push_a(8'h5A, 1);
      send_a(8'h5A, 1, 0);
      tick(CPB);
      check("ferr_wait_idle_busy", busy_a, 1);
      line_a = 1'b1;
      tick(4);
      check("ferr_back_to_idle", busy_a, 0);

      // Enable dropped mid-frame.
      p0 = pops_a;
      line_a = 1'b0; tick(CPB);
      line_a = 1'b1; tick(CPB);
      line_a = 1'b0; tick(CPB);
      enable_a = 1'b0;
      tick();
      check("abort_busy", busy_a, 0);
      line_a = 1'b1;
      tick(CPB);
      enable_a = 1'b1;
      tick(CPB);
      check("abort_entries", pops_a - p0, 0);

      // Reset during data bit 4, then a clean frame.
      line_a = 1'b0; tick(CPB);
      for (int i = 0; i < 4; i++) begin
         line_a = i[0];
         tick(CPB);
      end
      line_a = 1'b1;
      tick(CPB / 2);
      check("midframe_busy", busy_a, 1);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      check("post_rst_busy", busy_a, 0);
      check("post_rst_valid", m_valid_a, 0);
      tick(CPB);
      p0 = pops_a;
      model_push_a(8'h3C, 0);
      send_a(8'h3C, 0, 0);
      line_a = 1'b1;
      tick(CPB);
      check("rst_resume_entries", pops_a - p0, 1);

      // Even-parity table on monitor B.
      for (int i = 0; i < 8; i++) begin
         send_b(tbl[i].data, tbl[i].par, tbl[i].stop_low);
         line_b = 1'b1;
         w = 0;
         while (!m_valid_b && w < 4 * CPB) begin
            tick();
            w++;
         end
         check("b_valid", m_valid_b, 1);
         check("b_data", m_data_b, tbl[i].data);
         check("b_perr", m_perr_b, tbl[i].perr);
         check("b_ferr", m_ferr_b, tbl[i].ferr);
         check("b_break", m_break_b, tbl[i].brk);
         m_ready_b = 1'b1;
         tick();
         m_ready_b = 1'b0;
         check("b_popped", m_valid_b, 0);
         tick(CPB);
      end
      check("b_overflow", overflow_b, 0);
      check("b_drop_cnt", drop_cnt_b, 0);

      // Randomized frames with random back-pressure.
      for (int i = 0; i < 40; i++) begin
         d  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         sl = ($urandom_range(0, 5) == 0);
         model_push_a(d, sl);
         send_a(d, sl, 1);
         line_a = 1'b1;
         tick($urandom_range(2, 24));
      end
      m_ready_a = 1'b1;
      tick(CPB);
      check("rand_leftover", exp_q.size(), 0);
      check("rand_overflow", overflow_a, 0);

      // Six frames into a stalled 4-deep buffer.
      m_ready_a = 1'b0;
      for (int i = 0; i < 6; i++) begin
         model_push_a(8'h10 + 8'(i), 0);
         send_a(8'h10 + 8'(i), 0, 0);
         line_a = 1'b1;
         tick(4);
      end
      check("ovf_overflow", overflow_a, (drops_a != 0) ? 1 : 0);
      check("ovf_drop_cnt", drop_cnt_a, drops_a);
      check("ovf_drop_cnt_is_2", drop_cnt_a, 2);
      m_ready_a = 1'b1;
      tick(20);
      check("ovf_leftover", exp_q.size(), 0);
      check("ovf_sticky", overflow_a, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
